updi_rx_buffer: RTL

Receive-side buffer sitting directly downstream of the UART receiver in the UPDI datapath. It consumes the receiver's one-cycle data/error pulses and discards the echoes of bytes the host itself transmitted on the single-wire half-duplex UPDI line. Remaining bytes, each tagged with its parity-error status, are queued in a FIFO. Bytes leave the FIFO through a valid/ready interface toward the UPDI command sequencer.

---
 rtl/updi_rx_buffer.sv | 106 ++++++++++
 1 files changed

// File: rtl/updi_rx_buffer.sv
// updi_rx_buffer: receive-side buffer behind the UPDI UART receiver.
// It drops the echoes of bytes the host transmitted on the half-duplex
// line. It queues every other byte, together with its parity-error tag,
// in a FIFO that drains through a valid/ready port to the command
// sequencer.
module updi_rx_buffer #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic                     in_valid,
  input  logic                     in_error,
  input  logic                     echo_add,
  input  logic                     flush,
  output logic [DATA_BITS-1:0]     out_data,
  output logic                     out_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   echo_pending,
  output logic                     overflow,
  output logic                     echo_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ECHO_MAX = '1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry layout: {error_flag, data}; error entries always carry data 0.
  logic [DATA_BITS:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  logic               event_any;
  logic               echo_hit;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic [CW-1:0]      echo_nxt;
  logic [DATA_BITS:0] entry;
  logic [DATA_BITS:0] head;

  // Classify the incoming event and decide the push, the pop and the next echo count.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    echo_nxt  = echo_pending;
    event_any = in_valid | in_error;
    echo_hit  = event_any && (echo_pending != '0);
    push_req  = event_any && !echo_hit;
    pop       = out_valid && out_ready;
    push_ok   = push_req && ((count != FULL_CNT) || pop);
    entry     = in_error ? {1'b1, {DATA_BITS{1'b0}}} : {1'b0, in_data};
    if (echo_hit) begin
      // A same-cycle echo_add replaces the echo being consumed.
      if (!echo_add) echo_nxt = echo_pending - 1'b1;
    end else if (echo_add && (echo_pending != ECHO_MAX)) begin
      echo_nxt = echo_pending + 1'b1;
    end
  end

  // Control state: pointers, occupancy, echo counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      echo_pending <= '0;
      overflow     <= 1'b0;
      echo_error   <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      echo_pending <= '0;
      overflow     <= 1'b0;
      echo_error   <= 1'b0;
    end else begin
      echo_pending <= echo_nxt;
      if (echo_hit && in_error)   echo_error <= 1'b1;
      if (push_req && !push_ok)   overflow   <= 1'b1;
      if (push_ok)                wr_ptr     <= wr_ptr + 1'b1;
      if (pop)                    rd_ptr     <= rd_ptr + 1'b1;
      if (push_ok && !pop)        count      <= count + 1'b1;
      else if (!push_ok && pop)   count      <= count - 1'b1;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; out_valid masks whatever it holds.
    if (!flush && push_ok) mem[wr_ptr] <= entry;
  end

  // Head-of-FIFO outputs, forced to zero while the FIFO is empty.
  always_comb begin
    out_valid = (count != '0);
    head      = mem[rd_ptr];
    out_data  = out_valid ? head[DATA_BITS-1:0] : '0;
    out_error = out_valid ? head[DATA_BITS] : 1'b0;
  end

endmodule
